// File: rtl/seg_display.sv
// Four-digit multiplexed seven-segment driver showing MM.SS from a frame-coherent
// snapshot of the stopwatch fields, with optional blanking of the field being adjusted.
module seg_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       adj,
  input  logic       sel,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] R_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic [RW-1:0] ref_cnt;
  logic [BW-1:0] blk_cnt;
  logic          phase;
  logic [1:0]    idx;
  logic [5:0]    snap_min, snap_sec;

  logic [5:0] field;
  logic [3:0] tens, ones, digit;
  logic       blank;
  logic [6:0] seg_nx;
  logic [3:0] an_nx;
  logic       dp_nx;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0: enc = 7'b1000000;
      4'd1: enc = 7'b1111001;
      4'd2: enc = 7'b0100100;
      4'd3: enc = 7'b0110000;
      4'd4: enc = 7'b0011001;
      4'd5: enc = 7'b0010010;
      4'd6: enc = 7'b0000010;
      4'd7: enc = 7'b1111000;
      4'd8: enc = 7'b0000000;
      4'd9: enc = 7'b0010000;
      default: enc = BLANK;
    endcase
  endfunction

  // Compare-and-subtract split; only valid for 0..59, larger values show as dashes.
  always_comb begin
    field = idx[1] ? snap_min : snap_sec;
    tens  = 4'd0;
    ones  = field[3:0];
    if (field >= 6'd50)      begin tens = 4'd5; ones = 4'(field - 6'd50); end
    else if (field >= 6'd40) begin tens = 4'd4; ones = 4'(field - 6'd40); end
    else if (field >= 6'd30) begin tens = 4'd3; ones = 4'(field - 6'd30); end
    else if (field >= 6'd20) begin tens = 4'd2; ones = 4'(field - 6'd20); end
    else if (field >= 6'd10) begin tens = 4'd1; ones = 4'(field - 6'd10); end
    digit  = idx[0] ? tens : ones;
    // adj gates blanking directly so dropping it restores the display on the next edge
    blank  = adj & phase & (sel == ~idx[1]);
    seg_nx = blank ? BLANK : ((field >= 6'd60) ? DASH : enc(digit));
    an_nx  = blank ? 4'b1111 : ~(4'b0001 << idx);
    dp_nx  = ~((idx == 2'd2) & ~blank);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt  <= '0;
      blk_cnt  <= '0;
      phase    <= 1'b0;
      idx      <= 2'd0;
      snap_min <= 6'd0;
      snap_sec <= 6'd0;
      seg      <= BLANK;
      an       <= 4'b1111;
      dp       <= 1'b1;
    end else begin
      if (ref_cnt == R_LAST) begin
        ref_cnt <= '0;
        idx     <= idx + 2'd1;
        // sample once per frame so all four digits come from the same value
        if (idx == 2'd3) begin
          snap_min <= minutes;
          snap_sec <= seconds;
        end
      end else begin
        ref_cnt <= ref_cnt + 1'b1;
      end

      if (!adj) begin
        blk_cnt <= '0;
        phase   <= 1'b0;
      end else if (blk_cnt == B_LAST) begin
        blk_cnt <= '0;
        phase   <= ~phase;
      end else begin
        blk_cnt <= blk_cnt + 1'b1;
      end

      seg <= seg_nx;
      an  <= an_nx;
      dp  <= dp_nx;
    end
  end
endmodule

// File: tb/tb_seg_display.sv
// Bench for seg_display: directed vector table, blink/reset sequences, and random
// stimulus checked cycle by cycle against an arithmetic model of the display.
module tb_seg_display;
  localparam int R = 4;
  localparam int B = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       adj = 1'b0;
  logic       sel = 1'b0;
  logic [5:0] minutes = 6'd0;
  logic [5:0] seconds = 6'd0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  seg_display #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
    .clk(clk), .rst(rst), .adj(adj), .sel(sel),
    .minutes(minutes), .seconds(seconds),
    .seg(seg), .an(an), .dp(dp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: n = edges since reset release, k = consecutive adj edges, snapshot per frame
  int n = 0;
  int k = 0;
  int ms_min = 0;
  int ms_sec = 0;
  logic [6:0] seg_tab [10];

  typedef struct {
    logic [5:0] mn;
    logic [5:0] sc;
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } vec_t;
  vec_t tab [20];

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
               name, act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp, input bit eq);
    checks++;
    if ((act == exp) != eq) begin
      failures++;
      $display("FAIL %s: got %0d, want %s%0d", name, act, eq ? "" : "not ", exp);
    end
  endtask

  function automatic logic [11:0] model_out();
    int pos, ix, f, d;
    bit bl;
    logic [6:0] s;
    logic [3:0] a;
    if (rst) return {4'b1111, 7'b1111111, 1'b1};
    pos = n / R;
    ix  = pos % 4;
    f   = (ix >= 2) ? ms_min : ms_sec;
    d   = (ix % 2 == 1) ? f / 10 : f % 10;
    bl  = adj && ((k / B) % 2 == 1) && (sel == (ix < 2));
    s   = (f >= 60) ? 7'b0111111 : seg_tab[d];
    a   = 4'b1111;
    a[ix] = 1'b0;
    if (bl) return {4'b1111, 7'b1111111, 1'b1};
    return {a, s, (ix == 2) ? 1'b0 : 1'b1};
  endfunction

  task automatic tick();
    logic [11:0] exp;
    exp = model_out();
    @(posedge clk);
    #1;
    check("model", {an, seg, dp}, exp);
    if (rst) begin
      n = 0; k = 0; ms_min = 0; ms_sec = 0;
    end else begin
      n++;
      if (n % (4 * R) == 0) begin
        ms_min = int'(minutes);
        ms_sec = int'(seconds);
      end
      k = adj ? k + 1 : 0;
    end
  endtask

  initial begin
    int cnt;
    bit found;
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    tab[0]  = '{6'd59, 6'd7,  4, 4'b1110, 7'b1000000, 1'b1};
    tab[1]  = '{6'd59, 6'd7,  4, 4'b1101, 7'b1000000, 1'b1};
    tab[2]  = '{6'd59, 6'd7,  4, 4'b1011, 7'b1000000, 1'b0};
    tab[3]  = '{6'd59, 6'd7,  4, 4'b0111, 7'b1000000, 1'b1};
    tab[4]  = '{6'd59, 6'd7,  4, 4'b1110, 7'b1111000, 1'b1};
    tab[5]  = '{6'd59, 6'd7,  4, 4'b1101, 7'b1000000, 1'b1};
    tab[6]  = '{6'd59, 6'd7,  4, 4'b1011, 7'b0010000, 1'b0};
    tab[7]  = '{6'd59, 6'd7,  4, 4'b0111, 7'b0010010, 1'b1};
    tab[8]  = '{6'd59, 6'd7,  4, 4'b1110, 7'b1111000, 1'b1};
    tab[9]  = '{6'd59, 6'd8,  4, 4'b1101, 7'b1000000, 1'b1};
    tab[10] = '{6'd59, 6'd8,  4, 4'b1011, 7'b0010000, 1'b0};
    tab[11] = '{6'd59, 6'd8,  4, 4'b0111, 7'b0010010, 1'b1};
    tab[12] = '{6'd59, 6'd62, 4, 4'b1110, 7'b0000000, 1'b1};
    tab[13] = '{6'd59, 6'd62, 4, 4'b1101, 7'b1000000, 1'b1};
    tab[14] = '{6'd59, 6'd62, 4, 4'b1011, 7'b0010000, 1'b0};
    tab[15] = '{6'd59, 6'd62, 4, 4'b0111, 7'b0010010, 1'b1};
    tab[16] = '{6'd59, 6'd62, 4, 4'b1110, 7'b0111111, 1'b1};
    tab[17] = '{6'd59, 6'd62, 4, 4'b1101, 7'b0111111, 1'b1};
    tab[18] = '{6'd59, 6'd62, 4, 4'b1011, 7'b0010000, 1'b0};
    tab[19] = '{6'd59, 6'd62, 4, 4'b0111, 7'b0010010, 1'b1};

    // reset for 3 cycles
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
    end
    rst = 1'b0;

    // scan, decode, snapshot coherence, out-of-range
    for (int i = 0; i < 20; i++) begin
      minutes = tab[i].mn;
      seconds = tab[i].sc;
      for (int c = 0; c < tab[i].cyc; c++) begin
        tick();
        check($sformatf("vec%0d", i), {an, seg, dp}, {tab[i].an, tab[i].seg, tab[i].dp});
      end
    end

    // blink on seconds: 16 visible then 16 blanked
    minutes = 6'd12; seconds = 6'd34; adj = 1'b1; sel = 1'b1;
    cnt = 0;
    for (int c = 0; c < 16; c++) begin tick(); if (an[1:0] != 2'b11) cnt++; end
    check_int("blink_vis_sec", cnt, 0, 1'b0);
    cnt = 0;
    for (int c = 0; c < 16; c++) begin tick(); if (an[1:0] != 2'b11) cnt++; end
    check_int("blink_blank_sec", cnt, 0, 1'b1);
    for (int c = 0; c < 16; c++) tick();
    // switch field while blanking
    sel = 1'b0;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin tick(); if (an[3:2] != 2'b11) cnt++; end
    check_int("blink_blank_min", cnt, 0, 1'b1);
    adj = 1'b0;
    tick();
    check("adj_fall", {an, seg, dp}, {4'b1011, 7'b0100100, 1'b0});

    // reset while minutes are blanked at index 2
    adj = 1'b1; sel = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (((n / R) % 4 == 2) && ((k / B) % 2 == 1)) found = 1'b1;
      else tick();
    end
    check_int("seek_blank_idx2", int'(found), 1, 1'b1);
    rst = 1'b1;
    tick();
    check("rst_mid", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
    tick();
    rst = 1'b0;
    tick();
    check("rst_release", {an, seg, dp}, {4'b1110, 7'b1000000, 1'b1});
    for (int c = 0; c < 20; c++) tick();

    // random stimulus against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) minutes = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) seconds = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 39) == 0) adj = ~adj;
      if ($urandom_range(0, 19) == 0) sel = ~sel;
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
